// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
//
// Word-organised data memory for the MEM stage of the 5-stage pipelined CPU.
// The address comes from EX_MEM_ALUOut, the write data from EX_MEM_B, and
// memRead/memWrite from the EX/MEM pipeline register.
//
// Reads are combinational, so MEM_WB can capture the result on the same
// clock edge. Writes happen on the rising edge of clk. Accesses are forced
// word-aligned because address[1:0] is ignored. An address is in range only
// when it is below 4*DEPTH. Out-of-range writes are dropped, and
// out-of-range reads return 0. There is no aliasing.
//
// Parameters:
//   DEPTH      number of 32-bit words stored (power of two, >= 4)
//   ADDR_W     width of the byte address input
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset, clears every word
//   address    byte address of the access
//   writeData  data to store
//   memRead    read enable
//   memWrite   write enable
//   readData   combinational read result (0 when not reading / out of range)
//   err        (only with DATA_MEM_ERR_EN) combinational access error flag
//
// Optional feature macro: DATA_MEM_ERR_EN
//   When this macro is defined, the err output is added. err flags an active
//   access (read or write) that is out of range or misaligned. err is held
//   at 0 while reset is high. err does not change how the access behaves.
// ---------------------------------------------------------------------------
module data_mem #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writeData,
   input  logic              memRead,
   input  logic              memWrite,
   output logic [31:0]       readData
`ifdef DATA_MEM_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] word_idx;
   logic             in_range;

   assign word_idx = address[IDX_W+1:2];

   // The range test requires every address bit above the word index to be
   // zero. This rejects wrapped addresses, so a high address cannot alias
   // onto a low word.
   generate
      if (ADDR_W > IDX_W + 2) begin : g_range
         assign in_range = (address[ADDR_W-1:IDX_W+2] == '0);
      end else begin : g_full_range
         assign in_range = 1'b1;
      end
   endgenerate

   // Reset takes priority over a simultaneous write, so that write is lost.
   // A memWrite that is anything other than a clean 1 does not write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (memWrite == 1'b1 && in_range) begin
         mem[word_idx] <= writeData;
      end
   end

   always_comb begin
      readData = 32'h0;
      if (memRead && in_range) begin
         readData = mem[word_idx];
      end
   end

`ifdef DATA_MEM_ERR_EN
   always_comb begin
      err = 1'b0;
      if (!reset && (memRead || memWrite)) begin
         err = !in_range || (address[1:0] != 2'b00);
      end
   end
`else
   // Without the error flag, the byte-offset bits have no consumer.
   logic unused_addr_bits;
   assign unused_addr_bits = ^address[1:0];
`endif

endmodule

// File: tb/tb_data_mem.sv
// ---------------------------------------------------------------------------
// tb_data_mem
//
// Self-checking bench for data_mem with DEPTH=256. A reference memory is held
// as a plain array of words indexed by address/4. The reference model
// applies the rules directly: an address is legal when it is below
// 4*DEPTH, reset clears everything, and a write lands only when legal.
// Build with +define+DATA_MEM_ERR_EN to also check the err output.
// ---------------------------------------------------------------------------
module tb_data_mem;

   localparam int DEPTH = 256;
   localparam int LIMIT = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memRead;
   logic        memWrite;
   logic [31:0] readData;
`ifdef DATA_MEM_ERR_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] model [DEPTH];

   data_mem #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .writeData (writeData),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .readData  (readData)
`ifdef DATA_MEM_ERR_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   // Expected combinational read value, taken from the reference array.
   function automatic logic [31:0] expect_read(input logic rd, input logic [31:0] a);
      if (rd && a < LIMIT) return model[a / 4];
      return 32'h0;
   endfunction

   // Expected error flag: an active access that is out of range or not
   // word-aligned, suppressed while reset is high.
   function automatic logic expect_err(input logic rst, input logic rd, input logic wr,
                                       input logic [31:0] a);
      if (rst) return 1'b0;
      if (!(rd || wr)) return 1'b0;
      return (a >= LIMIT) || (a % 4 != 0);
   endfunction

   // Advance one rising edge. The reference model applies the same edge
   // effects, then the bench settles just past the edge.
   task automatic commit_edge();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      end else if (memWrite === 1'b1 && address < LIMIT) begin
         model[address / 4] = writeData;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] addrs [3];
      addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd1020;
      reset = 1'b1; memWrite = 1'b0; memRead = 1'b0;
      commit_edge();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         address = addrs[i]; memRead = 1'b1;
         #1;
         checks++;
         if (readData !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_read addr=%0d got=%h want=%h", addrs[i], readData, 32'h0);
         end
      end
      memRead = 1'b0;
   endtask

   task automatic test_write_read();
      address = 32'd8; writeData = 32'hDEADBEEF; memWrite = 1'b1; memRead = 1'b0;
      #1;
      checks++;
      if (readData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL idle_read_during_write got=%h want=%h", readData, 32'h0);
      end
      commit_edge();
      memWrite = 1'b0; memRead = 1'b1;
      #1;
      checks++;
      if (readData !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL write_readback got=%h want=%h", readData, 32'hDEADBEEF);
      end
      memRead = 1'b0;
      #1;
      checks++;
      if (readData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL read_disabled got=%h want=%h", readData, 32'h0);
      end
   endtask

   task automatic test_misaligned();
      address = 32'd12; writeData = 32'h12345678; memWrite = 1'b1; memRead = 1'b0;
      commit_edge();
      memWrite = 1'b0; memRead = 1'b1;
      address = 32'd13;
      #1;
      checks++;
      if (readData !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL misaligned_read13 got=%h want=%h", readData, 32'h12345678);
      end
`ifdef DATA_MEM_ERR_EN
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_misaligned13 got=%b want=1", err);
      end
`endif
      address = 32'd15;
      #1;
      checks++;
      if (readData !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL misaligned_read15 got=%h want=%h", readData, 32'h12345678);
      end
      address = 32'd12;
      #1;
`ifdef DATA_MEM_ERR_EN
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_aligned12 got=%b want=0", err);
      end
`endif
      memRead = 1'b0;
   endtask

   task automatic test_out_of_range();
      // Check the last legal word first, then the first illegal address.
      address = 32'd1020; writeData = 32'h0BADF00D; memWrite = 1'b1; memRead = 1'b0;
      commit_edge();
      memWrite = 1'b0; memRead = 1'b1;
      #1;
      checks++;
      if (readData !== 32'h0BADF00D) begin
         errors++;
         $display("[TB] FAIL top_word_readback got=%h want=%h", readData, 32'h0BADF00D);
      end
      address = 32'd1024; writeData = 32'hAAAAAAAA; memWrite = 1'b1; memRead = 1'b0;
      #1;
`ifdef DATA_MEM_ERR_EN
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_out_of_range got=%b want=1", err);
      end
`endif
      commit_edge();
      memWrite = 1'b0; memRead = 1'b1;
      #1;
      checks++;
      if (readData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL oor_read1024 got=%h want=%h", readData, 32'h0);
      end
      address = 32'd0;
      #1;
      checks++;
      if (readData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL oor_no_alias_addr0 got=%h want=%h", readData, 32'h0);
      end
      memRead = 1'b0;
   endtask

   task automatic test_simultaneous();
      address = 32'd16; writeData = 32'd5; memWrite = 1'b1; memRead = 1'b0;
      commit_edge();
      writeData = 32'd9; memRead = 1'b1;
      #1;
      checks++;
      if (readData !== 32'd5) begin
         errors++;
         $display("[TB] FAIL rw_before_edge got=%h want=%h", readData, 32'd5);
      end
      commit_edge();
      checks++;
      if (readData !== 32'd9) begin
         errors++;
         $display("[TB] FAIL rw_after_edge got=%h want=%h", readData, 32'd9);
      end
      memWrite = 1'b0; memRead = 1'b0;
   endtask

   task automatic test_reset_vs_write();
      reset = 1'b1; memWrite = 1'b1; memRead = 1'b1;
      address = 32'd1025; writeData = 32'd7;
      #1;
`ifdef DATA_MEM_ERR_EN
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_during_reset got=%b want=0", err);
      end
`endif
      address = 32'd20; memRead = 1'b0;
      commit_edge();
      reset = 1'b0; memWrite = 1'b0; memRead = 1'b1;
      #1;
      checks++;
      if (readData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_beats_write got=%h want=%h", readData, 32'h0);
      end
      address = 32'd8;
      #1;
      checks++;
      if (readData !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_clears_addr8 got=%h want=%h", readData, 32'h0);
      end
      memRead = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] exp_data;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0:       address = $urandom();
            1:       address = 32'(LIMIT) - 32'd8 + 32'($urandom_range(0, 15));
            default: address = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
         endcase
         writeData = $urandom();
         memRead   = 1'($urandom_range(0, 1));
         memWrite  = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 39) == 0);
         #1;
         exp_data = expect_read(memRead, address);
         checks++;
         if (readData !== exp_data) begin
            errors++;
            $display("[TB] FAIL random_read n=%0d addr=%h got=%h want=%h", n, address, readData, exp_data);
         end
`ifdef DATA_MEM_ERR_EN
         checks++;
         if (err !== expect_err(reset, memRead, memWrite, address)) begin
            errors++;
            $display("[TB] FAIL random_err n=%0d addr=%h got=%b want=%b", n, address, err,
                     expect_err(reset, memRead, memWrite, address));
         end
`endif
         commit_edge();
      end
      reset = 1'b0; memWrite = 1'b0; memRead = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog timeout got=running want=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; address = '0; writeData = '0; memRead = 1'b0; memWrite = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      #1;
      test_reset();
      test_write_read();
      test_misaligned();
      test_out_of_range();
      test_simultaneous();
      test_reset_vs_write();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
